// File: rtl/maze_solver_if.sv
// Maze solver stream bundle: serial maze bits in, 2-bit moves out.
// Master is the pattern generator; slave is the solver.
interface maze_solver_if;
  logic       in_valid;
  logic       in;
  logic       out_valid;
  logic [1:0] out;

  modport master (output in_valid, in, input out_valid, out);
  modport slave  (input in_valid, in, output out_valid, out);
endinterface

// File: rtl/maze_solver.sv
// 17x17 serial maze solver: loads 289 bits, walks start->goal, streams one move per cycle.
// Solve is 1 cycle, or iterative dead-end fill when MAZE_DEADEND_FILL_EN; no output backpressure.
module maze_solver #(
  parameter int N  = 17,
  parameter int CW = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  maze_solver_if.slave io
);
  localparam int CELLS = N * N;
  localparam int KW    = $clog2(CELLS + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
`ifdef MAZE_DEADEND_FILL_EN
  localparam int NTRY = 3;
`else
  localparam int NTRY = 4;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, SOLVE, OUT} state_t;

  state_t           state_q, state_d;
  logic [CELLS-1:0] map_q, map_d;
  logic [KW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    row_q, row_d, col_q, col_d;
  logic [1:0]       head_q, head_d;
  logic             out_valid_c;
  logic [1:0]       out_c;

  // Neighbour coordinates wrap to 31 below zero, so a single <= LAST test rejects both edges.
  function automatic logic is_open(input logic [CELLS-1:0] m, input logic [CW-1:0] r,
                                   input logic [CW-1:0] c);
    logic [KW-1:0] idx;
    idx     = KW'(r) * KW'(N) + KW'(c);
    is_open = 1'b0;
    if (r <= LAST && c <= LAST) is_open = m[idx];
  endfunction

  function automatic logic [2*CW-1:0] step(input logic [CW-1:0] r, input logic [CW-1:0] c,
                                           input logic [1:0] d);
    case (d)
      2'd0:    step = {r, c + CW'(1)};
      2'd1:    step = {r + CW'(1), c};
      2'd2:    step = {r, c - CW'(1)};
      default: step = {r - CW'(1), c};
    endcase
  endfunction

  // Heading offsets in priority order: right turn, straight, left turn, reverse.
  function automatic logic [1:0] turn_off(input int i);
    case (i)
      0:       turn_off = 2'd1;
      1:       turn_off = 2'd0;
      2:       turn_off = 2'd3;
      default: turn_off = 2'd2;
    endcase
  endfunction

`ifdef MAZE_DEADEND_FILL_EN
  logic [CELLS-1:0] kill;
  for (genvar gr = 0; gr < N; gr++) begin : g_row
    for (genvar gc = 0; gc < N; gc++) begin : g_col
      if (gr * N + gc == 0 || gr * N + gc == CELLS - 1) begin : g_keep
        assign kill[gr*N+gc] = 1'b0;
      end else begin : g_fill
        logic [2:0] nbr;
        assign nbr = 3'(is_open(map_q, CW'(gr + 1), CW'(gc)))
                   + 3'(is_open(map_q, CW'(gr - 1), CW'(gc)))
                   + 3'(is_open(map_q, CW'(gr), CW'(gc + 1)))
                   + 3'(is_open(map_q, CW'(gr), CW'(gc - 1)));
        assign kill[gr*N+gc] = map_q[gr*N+gc] && (nbr <= 3'd1);
      end
    end
  end
`endif

  logic [1:0]      try_dir, mv_dir;
  logic [2*CW-1:0] try_rc, mv_rc;
  logic            mv_ok;

  always_comb begin
    mv_ok   = 1'b0;
    mv_dir  = head_q;
    mv_rc   = {row_q, col_q};
    try_dir = 2'd0;
    try_rc  = '0;
    for (int i = 0; i < NTRY; i++) begin
      try_dir = head_q + turn_off(i);
      try_rc  = step(row_q, col_q, try_dir);
      if (!mv_ok && is_open(map_q, try_rc[2*CW-1:CW], try_rc[CW-1:0])) begin
        mv_ok  = 1'b1;
        mv_dir = try_dir;
        mv_rc  = try_rc;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    map_d       = map_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    col_d       = col_q;
    head_d      = head_q;
    out_valid_c = 1'b0;
    out_c       = 2'd0;
    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          map_d   = {io.in, map_q[CELLS-1:1]};
          cnt_d   = KW'(1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (io.in_valid) begin
          map_d = {io.in, map_q[CELLS-1:1]};
          cnt_d = cnt_q + KW'(1);
          if (cnt_q == KW'(CELLS - 1)) state_d = SOLVE;
        end
      end
      SOLVE: begin
        row_d  = '0;
        col_d  = '0;
        head_d = 2'd0;
`ifdef MAZE_DEADEND_FILL_EN
        map_d = map_q & ~kill;
        if (kill == '0) state_d = OUT;
`else
        state_d = OUT;
`endif
      end
      OUT: begin
        out_valid_c = 1'b1;
        out_c       = mv_dir;
        if (mv_ok) begin
          row_d  = mv_rc[2*CW-1:CW];
          col_d  = mv_rc[CW-1:0];
          head_d = mv_dir;
          if (mv_rc == {LAST, LAST}) state_d = IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      map_q   <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      head_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      map_q   <= map_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      head_q  <= head_d;
    end
  end

  assign io.out_valid = out_valid_c;
  assign io.out       = out_c;
endmodule

// File: tb/tb_maze_solver.sv
// Directed and random-tree checks of maze_solver: exact move streams, path replay, latency, reset abort.
module tb_maze_solver;
  localparam int N     = 17;
  localparam int CELLS = N * N;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  maze_solver_if io ();
  maze_solver dut (.clk(clk), .rst_n(rst_n), .io(io));

  int               n_vec = 0;
  int               n_err = 0;
  int               zero_viol = 0;
  logic [CELLS-1:0] maze;
  int               got_q[$];
  int               exp_q[$];
  int               lat;

  always @(negedge clk) if (!io.out_valid && io.out != 2'd0) zero_viol++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    maze = '0;
  endtask

  task automatic opn(input int r, input int c);
    maze[r*N+c] = 1'b1;
  endtask

  task automatic opn_row(input int r, input int c0, input int c1);
    for (int c = c0; c <= c1; c++) opn(r, c);
  endtask

  task automatic opn_col(input int c, input int r0, input int r1);
    for (int r = r0; r <= r1; r++) opn(r, c);
  endtask

  task automatic add_run(input int d, input int n);
    repeat (n) exp_q.push_back(d);
  endtask

  task automatic send_bits(input int nbits);
    for (int k = 0; k < nbits; k++) begin
      @(negedge clk);
      io.in_valid = 1'b1;
      io.in       = maze[k];
    end
  endtask

  task automatic run_maze();
    send_bits(CELLS);
    @(negedge clk);
    io.in_valid = 1'b0;
    io.in       = 1'b0;
    got_q.delete();
    lat = 0;
    while (!io.out_valid && lat <= 450) begin
      @(negedge clk);
      lat++;
    end
    if (!io.out_valid) begin
      chk("first_move_timeout", 0, 1);
    end else begin
      while (io.out_valid && got_q.size() < 1300) begin
        got_q.push_back(int'(io.out));
        @(negedge clk);
      end
      if (io.out_valid) chk("move_stream_timeout", 0, 1);
    end
  endtask

  task automatic cmp_exp(input string tag);
    int n;
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_mv"}, got_q[i], exp_q[i]);
  endtask

  // Replays the moves on the bench's own copy of the map.
  task automatic validate(input string tag);
    int r, c, bad, rev;
    r = 0; c = 0; bad = 0; rev = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      case (got_q[i])
        0: c++;
        1: r++;
        2: c--;
        default: r--;
      endcase
      if (r < 0 || r >= N || c < 0 || c >= N) begin
        bad++;
        r = 0; c = 0;
      end else if (!maze[r*N+c]) begin
        bad++;
      end
      if (i > 0 && got_q[i] == (got_q[i-1] ^ 2)) rev++;
    end
    chk({tag, "_bad_moves"}, bad, 0);
    chk({tag, "_end_row"}, r, N - 1);
    chk({tag, "_end_col"}, c, N - 1);
    chk({tag, "_len_ok"}, (got_q.size() <= 1200), 1);
    chk({tag, "_lat_ok"}, (lat <= 400), 1);
`ifdef MAZE_DEADEND_FILL_EN
    chk({tag, "_reversals"}, rev, 0);
`endif
  endtask

  // Binary-tree carving over the even-coordinate nodes yields a loop-free maze.
  task automatic gen_tree();
    clr();
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < 9; j++) begin
        opn(2 * i, 2 * j);
        if (i == 8 && j < 8)      opn(16, 2 * j + 1);
        else if (j == 8 && i < 8) opn(2 * i + 1, 16);
        else if (i < 8 && j < 8) begin
          if ($urandom_range(1, 0) == 1) opn(2 * i, 2 * j + 1);
          else                           opn(2 * i + 1, 2 * j);
        end
      end
    end
  endtask

  task automatic map_row_col();
    clr();
    opn_row(0, 0, 16);
    opn_col(16, 0, 16);
    exp_q.delete();
    add_run(0, 16);
    add_run(1, 16);
  endtask

  initial begin
    int vcount;
    io.in_valid = 1'b0;
    io.in       = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_out", io.out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    map_row_col();
    run_maze();
    cmp_exp("row_col");
    validate("row_col");

    clr();
    opn_col(0, 0, 16);
    opn_row(16, 0, 16);
    exp_q.delete();
    add_run(1, 16);
    add_run(0, 16);
    run_maze();
    cmp_exp("col_row");
    validate("col_row");

    clr();
    opn_row(0, 0, 16);
    opn_row(8, 0, 16);
    opn_row(16, 0, 16);
    opn_col(16, 0, 8);
    opn_col(0, 8, 16);
    exp_q.delete();
    add_run(0, 16);
    add_run(1, 8);
    add_run(2, 16);
    add_run(1, 8);
    add_run(0, 16);
    run_maze();
    cmp_exp("serp");
    validate("serp");

    map_row_col();
    opn_col(5, 1, 3);
`ifndef MAZE_DEADEND_FILL_EN
    exp_q.delete();
    add_run(0, 5);
    add_run(1, 3);
    add_run(3, 3);
    add_run(0, 11);
    add_run(1, 16);
`endif
    run_maze();
    cmp_exp("deadend");
    validate("deadend");

    map_row_col();
    send_bits(150);
    @(negedge clk);
    rst_n       = 1'b0;
    io.in_valid = 1'b0;
    io.in       = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    vcount = 0;
    repeat (500) begin
      @(negedge clk);
      if (io.out_valid) vcount++;
    end
    chk("abort_no_output", vcount, 0);
    run_maze();
    cmp_exp("reload");

    for (int t = 0; t < 100; t++) begin
      gen_tree();
      run_maze();
      validate("rand");
    end

    chk("out_zero_when_idle", zero_viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
